// File: rtl/line_pkg.sv
// Shared definitions for the line rasteriser: FSM encoding,
// y-step direction codes and the default coordinate width.
package line_pkg;

   localparam int LINE_WIDTH = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic YSTEP_POS = 1'b0;
   localparam logic YSTEP_NEG = 1'b1;

endpackage

// File: rtl/line_raster_ctrl_precomp.sv
// Combinational Bresenham setup: steep swap, endpoint ordering,
// deltas and y-step direction.
module Precomputed_param
   import line_pkg::*;
#(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic signed [WIDTH-1:0] x0,
   input  logic signed [WIDTH-1:0] y0,
   input  logic signed [WIDTH-1:0] x1,
   input  logic signed [WIDTH-1:0] y1,
   output logic                    steep,
   output logic signed [WIDTH-1:0] x0_p,
   output logic signed [WIDTH-1:0] x1_p,
   output logic signed [WIDTH-1:0] y0_p,
   output logic signed [WIDTH-1:0] dx,
   output logic signed [WIDTH-1:0] dy,
   output logic                    ystep
);

   logic signed [WIDTH-1:0] dx_raw, dy_raw, adx, ady;
   logic signed [WIDTH-1:0] ax0, ay0, ax1, ay1;
   logic signed [WIDTH-1:0] y1_p, dy_raw_p;
   logic                    swap;

   always_comb begin
      dx_raw   = x1 - x0;
      dy_raw   = y1 - y0;
      adx      = dx_raw[WIDTH-1] ? -dx_raw : dx_raw;
      ady      = dy_raw[WIDTH-1] ? -dy_raw : dy_raw;
      steep    = ady > adx;
      ax0      = steep ? y0 : x0;
      ay0      = steep ? x0 : y0;
      ax1      = steep ? y1 : x1;
      ay1      = steep ? x1 : y1;
      // Always walk in ascending major-axis order
      swap     = ax0 > ax1;
      x0_p     = swap ? ax1 : ax0;
      x1_p     = swap ? ax0 : ax1;
      y0_p     = swap ? ay1 : ay0;
      y1_p     = swap ? ay0 : ay1;
      dx       = x1_p - x0_p;
      dy_raw_p = y1_p - y0_p;
      dy       = dy_raw_p[WIDTH-1] ? -dy_raw_p : dy_raw_p;
      ystep    = (y0_p < y1_p) ? YSTEP_POS : YSTEP_NEG;
   end

endmodule

// File: rtl/line_raster_ctrl.sv
// Line command sequencer: latches endpoints, runs setup, then
// steps Bresenham one pixel per accepted beat.
module line_raster_ctrl
   import line_pkg::*;
#(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] y1,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [WIDTH-1:0] pix_x,
   output logic [WIDTH-1:0] pix_y,
   output logic             pix_last,
   output logic             busy,
   output logic             done
);

   state_t state_q, state_d;

   logic signed [WIDTH-1:0] ex0_q, ey0_q, ex1_q, ey1_q;
   logic                    steep_c, ystep_c;
   logic signed [WIDTH-1:0] x0_c, x1_c, y0_c, dx_c, dy_c;

   logic                    steep_q, ystep_q;
   logic signed [WIDTH-1:0] x1_q, dx_q, dy_q;
   logic signed [WIDTH-1:0] cur_x_q, cur_y_q;
   logic signed [WIDTH:0]   err_q;

   logic signed [WIDTH:0]   dx_ext, dx_q_ext, dy_q_ext, err_e;
   logic                    at_end;

   Precomputed_param #(.WIDTH(WIDTH)) u_precomp (
      .x0    (ex0_q),
      .y0    (ey0_q),
      .x1    (ex1_q),
      .y1    (ey1_q),
      .steep (steep_c),
      .x0_p  (x0_c),
      .x1_p  (x1_c),
      .y0_p  (y0_c),
      .dx    (dx_c),
      .dy    (dy_c),
      .ystep (ystep_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cmd_valid) state_d = ST_SETUP;
         ST_SETUP: state_d = ST_DRAW;
         ST_DRAW:  if (pix_ready && at_end) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      pix_valid = (state_q == ST_DRAW);
      busy      = (state_q == ST_SETUP) || (state_q == ST_DRAW);
      done      = (state_q == ST_DONE);
      pix_last  = pix_valid && at_end;
      pix_x     = '0;
      pix_y     = '0;
      if (pix_valid) begin
         pix_x = steep_q ? cur_y_q : cur_x_q;
         pix_y = steep_q ? cur_x_q : cur_y_q;
      end
   end

   // Stepper datapath: err is one bit wider than the deltas
   always_comb begin
      at_end   = (cur_x_q == x1_q);
      dx_ext   = {dx_c[WIDTH-1], dx_c};
      dx_q_ext = {dx_q[WIDTH-1], dx_q};
      dy_q_ext = {dy_q[WIDTH-1], dy_q};
      err_e    = err_q - dy_q_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex0_q   <= '0;
         ey0_q   <= '0;
         ex1_q   <= '0;
         ey1_q   <= '0;
         steep_q <= 1'b0;
         ystep_q <= YSTEP_POS;
         x1_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
         err_q   <= '0;
      end else begin
         if (state_q == ST_IDLE && cmd_valid) begin
            ex0_q <= x0;
            ey0_q <= y0;
            ex1_q <= x1;
            ey1_q <= y1;
         end
         if (state_q == ST_SETUP) begin
            steep_q <= steep_c;
            ystep_q <= ystep_c;
            x1_q    <= x1_c;
            dx_q    <= dx_c;
            dy_q    <= dy_c;
            cur_x_q <= x0_c;
            cur_y_q <= y0_c;
            err_q   <= dx_ext >>> 1;
         end
         if (state_q == ST_DRAW && pix_ready && !at_end) begin
            cur_x_q <= cur_x_q + WIDTH'(1);
            if (err_e < 0) begin
               cur_y_q <= (ystep_q == YSTEP_POS) ? cur_y_q + WIDTH'(1)
                                                 : cur_y_q - WIDTH'(1);
               err_q   <= err_e + dx_q_ext;
            end else begin
               err_q   <= err_e;
            end
         end
      end
   end

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Directed bench for line_raster_ctrl: table of lines with
// hand-computed pixel lists plus stall and reset sequences.
module tb_line_raster_ctrl;

   localparam int W = 13;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic         pix_valid;
   logic         pix_ready = 1'b0;
   logic [W-1:0] pix_x, pix_y;
   logic         pix_last, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x0, y0, x1, y1;
      int first, n;
   } vec_t;

   vec_t vecs[7];
   int   ex[32];
   int   ey[32];

   line_raster_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .x0        (x0),
      .y0        (y0),
      .x1        (x1),
      .y1        (y1),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_last  (pix_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_pix_valid"}, int'(pix_valid), 0);
      chk({tag, "_pix_x"}, int'(pix_x), 0);
      chk({tag, "_pix_y"}, int'(pix_y), 0);
      chk({tag, "_pix_last"}, int'(pix_last), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic run_line(input int v, input bit stall);
      int k, budget, idx;
      bit held;
      logic [W-1:0] hx, hy;
      logic hl;
      @(negedge clk);
      chk("idle_cmd_ready", int'(cmd_ready), 1);
      x0 = W'(vecs[v].x0);
      y0 = W'(vecs[v].y0);
      x1 = W'(vecs[v].x1);
      y1 = W'(vecs[v].y1);
      cmd_valid = 1'b1;
      pix_ready = 1'b0;
      @(negedge clk);
      // A stray command during the line must be ignored
      cmd_valid = stall;
      x0 = W'(100); y0 = W'(9); x1 = W'(3); y1 = W'(50);
      chk("setup_busy", int'(busy), 1);
      chk("setup_no_pix", int'(pix_valid), 0);
      @(negedge clk);
      chk("first_pix_latency", int'(pix_valid), 1);
      k = 0; budget = 0; held = 1'b0;
      hx = '0; hy = '0; hl = 1'b0;
      while (k < vecs[v].n && budget < 400) begin
         chk("draw_cmd_ready", int'(cmd_ready), 0);
         if (held) begin
            chk("stall_x", int'(pix_x), int'(hx));
            chk("stall_y", int'(pix_y), int'(hy));
            chk("stall_last", int'(pix_last), int'(hl));
         end
         pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pix_valid && pix_ready) begin
            idx = vecs[v].first + k;
            chk($sformatf("line%0d_pix%0d_x", v, k), int'(pix_x), ex[idx]);
            chk($sformatf("line%0d_pix%0d_y", v, k), int'(pix_y), ey[idx]);
            chk($sformatf("line%0d_pix%0d_last", v, k), int'(pix_last),
                (k == vecs[v].n - 1) ? 1 : 0);
            k++;
            held = 1'b0;
            if (k == vecs[v].n) cmd_valid = 1'b0;
         end else begin
            held = pix_valid;
            hx = pix_x; hy = pix_y; hl = pix_last;
         end
         @(negedge clk);
         budget++;
      end
      if (k < vecs[v].n) chk("pixel_timeout", k, vecs[v].n);
      cmd_valid = 1'b0;
      pix_ready = 1'b0;
      chk("done_pulse", int'(done), 1);
      chk("done_no_pix", int'(pix_valid), 0);
      chk("done_not_busy", int'(busy), 0);
      chk("done_cmd_ready", int'(cmd_ready), 0);
      @(negedge clk);
      chk("after_done_low", int'(done), 0);
      chk("after_done_ready", int'(cmd_ready), 1);
      chk("after_done_idle", int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{0, 0, 3, 0, 0, 4};
      vecs[1] = '{2, 0, 0, 5, 4, 6};
      vecs[2] = '{0, 0, 3, 3, 10, 4};
      vecs[3] = '{3, 3, 0, 0, 14, 4};
      vecs[4] = '{7, 7, 7, 7, 18, 1};
      vecs[5] = '{0, 0, 5, 2, 19, 6};
      vecs[6] = '{0, 4, 6, 1, 25, 7};
      ex = '{0, 1, 2, 3,  2, 2, 1, 1, 0, 0,  0, 1, 2, 3,  0, 1, 2, 3,
             7,  0, 1, 2, 3, 4, 5,  0, 1, 2, 3, 4, 5, 6};
      ey = '{0, 0, 0, 0,  0, 1, 2, 3, 4, 5,  0, 1, 2, 3,  0, 1, 2, 3,
             7,  0, 0, 1, 1, 2, 2,  4, 4, 3, 3, 2, 2, 1};

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      for (int v = 0; v < 7; v++) run_line(v, 1'b0);
      run_line(5, 1'b1);

      // Abort mid-line with reset while the third pixel is shown
      @(negedge clk);
      x0 = W'(0); y0 = W'(0); x1 = W'(10); y1 = W'(0);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      pix_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_third_pix_x", int'(pix_x), 2);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("abort");
      rst = 1'b0;
      pix_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", int'(done), 0);
         chk("abort_no_pix", int'(pix_valid), 0);
      end
      run_line(0, 1'b0);
      run_line(1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
